demux32_steer: RTL
==================

Name: demux32_steer

Overview:
- Registered 1-to-2 demultiplexer for 32-bit datapath words; the write-direction counterpart of the 2:1 word selectors.
- Takes one valid/ready input stream and steers each accepted word into lane A (s=0) or lane B (s=1).
- Each lane has a one-entry holding register with its own valid/ready output handshake.
- Used on write-back paths where one result bus feeds two independent consumers.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when high together with in_valid.
- in_data  input  WIDTH  input word.
- s  input  1  lane select, sampled with the word: 0 = lane A, 1 = lane B.
- out_a_valid  output  1  lane A holds a word.
- out_a_ready  input  1  lane A consumer takes the word.
- out_a_data  output  WIDTH  lane A word.
- out_b_valid  output  1  lane B holds a word.
- out_b_ready  input  1  lane B consumer takes the word.
- out_b_data  output  WIDTH  lane B word.
- stall_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0, saturating.

Behaviour:
- Reset (clk edge with rst=1):
  - out_a_valid and out_b_valid = 0.
  - out_a_data and out_b_data = 0.
  - stall_cnt = 0.
  - Reset wins over every simultaneous event. Words held mid-operation are discarded, not delivered.
- Per-lane state machine, states EMPTY and FULL; out_x_valid = (state == FULL).
  - EMPTY -> FULL: accept to this lane.
  - FULL -> EMPTY: drain (out_x_valid & out_x_ready) with no accept to this lane.
  - FULL -> FULL: drain and accept in the same cycle. New word replaces the old one with no bubble, and valid stays 1.
- in_ready is combinational: s=0 gives in_ready = !out_a_valid | out_a_ready; s=1 gives the same form using lane B.
  - No combinational path from in_data to any output.
- Accept = in_valid & in_ready.
  - On accept, in_data loads into the selected lane's data register at the next edge.
  - Latency: accept in cycle N, word is visible at the lane output in cycle N+1.
  - The unselected lane is untouched. Its data and valid hold, and it may drain independently in the same cycle.
- The s input may change while a word is stalled. in_ready re-evaluates against the new s. No lane reservation is kept.
- Lane data registers change only on accept, or on reset. They hold their value after a drain.
- Out-of-order delivery between lanes is allowed. Order within a lane is preserved by construction, since the depth is 1.
- stall_cnt increments by 1 on each cycle with in_valid & !in_ready. It saturates at 2^CNT_W-1, with no wrap.

Optional Feature:
- Macro DEMUX32_STEER_BCAST_EN.
- When defined:
  - Adds input port bcast (1 bit).
  - When bcast=1, in_ready = (lane A can accept) & (lane B can accept), where "can accept" is the per-lane term above.
  - An accept with bcast=1 loads in_data into both lanes and sets both valids at the same edge.
  - s is ignored while bcast=1.
  - stall_cnt counts broadcast stalls by the same rule.
- When not defined: no bcast port; behaviour is exactly the base description.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> both valids 0, both data 0, stall_cnt 0, and no word accepted.
- Single steer: in_data=32'hDEADBEEF, s=1, in_valid=1 for one cycle, out_b_ready=0 -> next cycle out_b_valid=1, out_b_data=DEADBEEF, out_a_valid=0. Lane B holds the word until out_b_ready=1, then out_b_valid=0 on the following cycle.
- Backpressure: lane A FULL with 0x11111111, out_a_ready=0, present 0x22222222 with s=0 for 5 cycles -> in_ready=0, stall_cnt=5, lane A data stays 0x11111111. Raising out_a_ready -> same-cycle accept; next cycle lane A holds 0x22222222 and valid stays 1.
- Independent lanes: lane A FULL and stalled, present 0x33333333 with s=1 -> in_ready=1, lane B loads 0x33333333 next cycle, and lane A is unchanged.
- Streaming: out_a_ready=1 held, 4 back-to-back words 1,2,3,4 with s=0 -> in_ready=1 every cycle, out_a_data shows 1,2,3,4 on consecutive cycles, stall_cnt=0.
- Saturation and mid-reset: set CNT_W=4 and stall for 20 cycles -> stall_cnt=15. Then assert rst with both lanes FULL -> both valids 0 and stall_cnt 0 on the next cycle.

Source files
------------

// File: rtl/demux32_steer.sv
// ============================================================================
// Module   : demux32_steer
// Purpose  : Registered 1-to-2 demultiplexer for datapath words. One
//            valid/ready input stream is steered into lane A (s=0) or lane B
//            (s=1); each lane is a one-entry holding register with its own
//            valid/ready handshake. A saturating counter tracks input stalls.
// Options  : DEMUX32_STEER_BCAST_EN adds a bcast input that loads the word
//            into both lanes at once.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux32_steer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             s,
`ifdef DEMUX32_STEER_BCAST_EN
   input  logic             bcast,
`endif
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [WIDTH-1:0] out_b_data,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [0:0]       c_st_empty = 1'b0;
   localparam logic [0:0]       c_st_full  = 1'b1;
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

   logic [0:0]       r_state_a;
   logic [0:0]       r_state_b;
   logic [0:0]       w_next_a;
   logic [0:0]       w_next_b;
   logic [WIDTH-1:0] r_data_a;
   logic [WIDTH-1:0] r_data_b;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_a_can;
   logic w_b_can;
   logic w_sel_a;
   logic w_sel_b;
   logic w_accept;
   logic w_acc_a;
   logic w_acc_b;
   logic w_bcast;

`ifdef DEMUX32_STEER_BCAST_EN
   assign w_bcast = bcast;
`else
   assign w_bcast = 1'b0;
`endif

   // Lane selection and the combinational ready; in_data never reaches this path
   always_comb begin
      w_a_can = (r_state_a == c_st_empty) | out_a_ready;
      w_b_can = (r_state_b == c_st_empty) | out_b_ready;
      // A broadcast needs both lanes free and ignores s
      w_sel_a = w_bcast | ~s;
      w_sel_b = w_bcast | s;
      if (w_bcast) begin
         in_ready = w_a_can & w_b_can;
      end else if (s) begin
         in_ready = w_b_can;
      end else begin
         in_ready = w_a_can;
      end
      w_accept = in_valid & in_ready;
      w_acc_a  = w_accept & w_sel_a;
      w_acc_b  = w_accept & w_sel_b;
   end

   // Lane state registers; reset discards any held word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_a <= c_st_empty;
         r_state_b <= c_st_empty;
      end else begin
         r_state_a <= w_next_a;
         r_state_b <= w_next_b;
      end
   end

   // Next-state logic: an accept always leaves the lane FULL, even while draining
   always_comb begin
      w_next_a = r_state_a;
      w_next_b = r_state_b;
      case (r_state_a)
         c_st_empty: if (w_acc_a)                   w_next_a = c_st_full;
         c_st_full:  if (!w_acc_a && out_a_ready)   w_next_a = c_st_empty;
         default:                                   w_next_a = c_st_empty;
      endcase
      case (r_state_b)
         c_st_empty: if (w_acc_b)                   w_next_b = c_st_full;
         c_st_full:  if (!w_acc_b && out_b_ready)   w_next_b = c_st_empty;
         default:                                   w_next_b = c_st_empty;
      endcase
   end

   // Output decode: a lane is valid exactly while it is FULL
   always_comb begin
      out_a_valid = (r_state_a == c_st_full);
      out_b_valid = (r_state_b == c_st_full);
      out_a_data  = r_data_a;
      out_b_data  = r_data_b;
      stall_cnt   = r_stall_cnt;
   end

   // Lane data registers load only on accept; they keep their value after a drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_a <= '0;
         r_data_b <= '0;
      end else begin
         if (w_acc_a) r_data_a <= in_data;
         if (w_acc_b) r_data_b <= in_data;
      end
   end

   // Saturating count of cycles where a presented word is refused
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (in_valid && !in_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire
